pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl_if.sv | 24 ++
 rtl/pc_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bundle: instruction-memory request/response plus the
// backend-facing instruction buffer, stall and redirect.
interface pc_fetch_ctrl_if;
    logic        Stall;
    logic        Redirect;
    logic [31:0] Redirect_Pc;
    logic        I_req;
    logic [31:0] I_addr;
    logic        I_ready;
    logic [31:0] I_rdata;
    logic        Inst_valid;
    logic [31:0] Inst;
    logic [31:0] Inst_pc;

    modport master (
        input  Stall, Redirect, Redirect_Pc, I_ready, I_rdata,
        output I_req, I_addr, Inst_valid, Inst, Inst_pc
    );

    modport slave (
        output Stall, Redirect, Redirect_Pc, I_ready, I_rdata,
        input  I_req, I_addr, Inst_valid, Inst, Inst_pc
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, a registered
// output buffer and a one-entry skid buffer for responses that land during a stall.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFetch   = 2'd1,
        StHold    = 2'd2,
        StDiscard = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] disc_addr_q, disc_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;

    logic        consume;
    logic        buf_free;
    logic [31:0] redirect_target;
    logic [31:0] pc_inc;

    assign consume         = inst_valid_q & ~bus.Stall;
    assign buf_free        = ~inst_valid_q | ~bus.Stall;
    assign redirect_target = bus.Redirect_Pc & 32'hFFFF_FFFC;
    assign pc_inc          = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        disc_addr_d  = disc_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;

        if (consume) begin
            inst_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (bus.Redirect) begin
                    inst_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                    pc_d         = redirect_target;
                    // Request still in flight: remember its address so it stays stable.
                    if (!bus.I_ready) begin
                        disc_addr_d = pc_q;
                        state_d     = StDiscard;
                    end
                end else if (bus.I_ready) begin
                    pc_d = pc_inc;
                    if (buf_free) begin
                        inst_valid_d = 1'b1;
                        inst_d       = bus.I_rdata;
                        inst_pc_d    = pc_q;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_inst_d  = bus.I_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = StHold;
                    end
                end
            end
            StHold: begin
                if (bus.Redirect) begin
                    inst_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                    pc_d         = redirect_target;
                    state_d      = StFetch;
                end else if (!bus.Stall) begin
                    inst_valid_d = skid_valid_q;
                    inst_d       = skid_inst_q;
                    inst_pc_d    = skid_pc_q;
                    skid_valid_d = 1'b0;
                    state_d      = StFetch;
                end
            end
            StDiscard: begin
                if (bus.Redirect) begin
                    inst_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                    pc_d         = redirect_target;
                end
                if (bus.I_ready) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Request outputs are registered from the next state, so they are glitch-free.
        req_d  = (state_d == StFetch) || (state_d == StDiscard);
        addr_d = (state_d == StDiscard) ? disc_addr_d : pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            disc_addr_q  <= 32'h0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= 32'h0;
            skid_pc_q    <= 32'h0;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            disc_addr_q  <= disc_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
        end
    end

    assign bus.I_req      = req_q;
    assign bus.I_addr     = addr_q;
    assign bus.Inst_valid = inst_valid_q;
    assign bus.Inst       = inst_q;
    assign bus.Inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by randomized traffic,
// checked against a program-order model of the delivered instruction stream.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RstPc = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    pc_fetch_ctrl_if bus ();

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    assign bus.I_rdata = memfn(bus.I_addr);

    pc_fetch_ctrl #(.RESET_PC(RstPc)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int consumes = 0;

    // State of the reference model, carried between cycles.
    logic        p_valid = 1'b0;
    logic        p_rst   = 1'b1;
    logic        p_req_hold, p_redir, p_stall_hold;
    logic [31:0] p_addr, p_inst, p_ipc;
    logic [31:0] exp_pc = RstPc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called with this cycle's inputs applied, just before the rising edge.
    task automatic model_step();
        if (p_valid) begin
            if (p_rst) begin
                chk("rst_req", bus.I_req, 1'b0);
                chk("rst_valid", bus.Inst_valid, 1'b0);
            end
            if (p_req_hold) begin
                chk("req_stable", bus.I_req, 1'b1);
                chk("addr_stable", bus.I_addr, p_addr);
            end
            if (p_redir) chk("redir_flush", bus.Inst_valid, 1'b0);
            if (p_stall_hold) begin
                chk("stall_valid", bus.Inst_valid, 1'b1);
                chk("stall_inst", bus.Inst, p_inst);
                chk("stall_pc", bus.Inst_pc, p_ipc);
            end
        end
        if (!rst) begin
            if (bus.Inst_valid && !bus.Stall) begin
                chk("order_pc", bus.Inst_pc, exp_pc);
                chk("order_inst", bus.Inst, memfn(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumes++;
            end
            if (bus.Redirect && !p_rst) exp_pc = bus.Redirect_Pc & 32'hFFFF_FFFC;
        end else begin
            exp_pc = RstPc;
        end
        p_valid      = 1'b1;
        p_req_hold   = !rst && bus.I_req && !bus.I_ready;
        p_addr       = bus.I_addr;
        p_redir      = !rst && !p_rst && bus.Redirect;
        p_stall_hold = !rst && !bus.Redirect && bus.Inst_valid && bus.Stall;
        p_inst       = bus.Inst;
        p_ipc        = bus.Inst_pc;
        p_rst        = rst;
    endtask

    task automatic drive(input logic r, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic rdy);
        rst             = r;
        bus.Stall       = st;
        bus.Redirect    = rd;
        bus.Redirect_Pc = rpc;
        bus.I_ready     = rdy;
        #1;
        model_step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int c0;
        logic r, st, rd, rdy;
        logic [31:0] rpc;

        // Reset state
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);
        chk("reset_req", bus.I_req, 1'b0);
        chk("reset_valid", bus.Inst_valid, 1'b0);
        chk("reset_inst", bus.Inst, 32'h0);
        chk("reset_inst_pc", bus.Inst_pc, 32'h0);

        // Idle cycle, then the first request at RESET_PC
        drive(0, 0, 0, 0, 1);
        chk("first_req", bus.I_req, 1'b1);
        chk("first_addr", bus.I_addr, RstPc);

        // Back-to-back fetch at one instruction per cycle
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 0, 1);
            chk("b2b_addr", bus.I_addr, 32'(4 * k));
            chk("b2b_valid", bus.Inst_valid, 1'b1);
            chk("b2b_pc", bus.Inst_pc, 32'(4 * (k - 1)));
            chk("b2b_inst", bus.Inst, memfn(32'(4 * (k - 1))));
        end

        // Memory wait states on the fetch at 0x10
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0);
            chk("wait_req", bus.I_req, 1'b1);
            chk("wait_addr", bus.I_addr, 32'h10);
        end
        drive(0, 0, 0, 0, 1);
        chk("wait_pc", bus.Inst_pc, 32'h10);
        chk("wait_valid", bus.Inst_valid, 1'b1);

        // Response for 0x14 lands while 0x10 is stalled -> skid, hold
        drive(0, 1, 0, 0, 1);
        chk("hold_req", bus.I_req, 1'b0);
        chk("hold_pc", bus.Inst_pc, 32'h10);
        drive(0, 1, 0, 0, 1);
        chk("hold_req2", bus.I_req, 1'b0);
        drive(0, 0, 0, 0, 0);
        chk("unskid_pc", bus.Inst_pc, 32'h14);
        chk("unskid_valid", bus.Inst_valid, 1'b1);
        chk("resume_addr", bus.I_addr, 32'h18);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("pre_redir_addr", bus.I_addr, 32'h20);

        // Redirect while 0x20 is outstanding -> discard, then 0x100
        drive(0, 0, 1, 32'h103, 0);
        chk("disc_addr", bus.I_addr, 32'h20);
        chk("disc_valid", bus.Inst_valid, 1'b0);
        drive(0, 0, 0, 0, 0);
        chk("disc_addr2", bus.I_addr, 32'h20);
        drive(0, 0, 0, 0, 1);
        chk("disc_drop", bus.Inst_valid, 1'b0);
        chk("redir_addr", bus.I_addr, 32'h100);
        drive(0, 0, 0, 0, 1);
        chk("redir_pc", bus.Inst_pc, 32'h100);

        // Redirect with Stall in hold -> skid discarded
        drive(0, 1, 0, 0, 1);
        chk("hold2_req", bus.I_req, 1'b0);
        drive(0, 1, 1, 32'h200, 0);
        chk("hredir_valid", bus.Inst_valid, 1'b0);
        chk("hredir_addr", bus.I_addr, 32'h200);
        drive(0, 0, 0, 0, 0);
        chk("hredir_noskid", bus.Inst_valid, 1'b0);
        drive(0, 0, 0, 0, 1);
        chk("hredir_pc", bus.Inst_pc, 32'h200);

        // Reset in the middle of a discard
        drive(0, 0, 1, 32'h300, 0);
        chk("disc3_addr", bus.I_addr, 32'h204);
        drive(1, 0, 0, 0, 0);
        chk("mrst_req", bus.I_req, 1'b0);
        chk("mrst_valid", bus.Inst_valid, 1'b0);
        drive(0, 0, 0, 0, 1);
        chk("mrst_addr", bus.I_addr, RstPc);

        // Pc wraps modulo 2^32
        drive(0, 0, 1, 32'hFFFF_FFFF, 1);
        chk("wrap_addr0", bus.I_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 1);
        chk("wrap_pc", bus.Inst_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", bus.I_addr, 32'h0);

        // Randomized traffic
        c0 = consumes;
        for (int i = 0; i < 1500; i++) begin
            r   = ($urandom_range(199) == 0);
            st  = ($urandom_range(9) < 3);
            rd  = ($urandom_range(24) == 0);
            rpc = $urandom;
            rdy = ($urandom_range(9) < 6);
            drive(r, st, rd, rpc, rdy);
        end
        chk("progress", 32'((consumes - c0) >= 200), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
